// File: rtl/pcpi_nibble_sequencer_if.sv
// Bundle of host nibble port, PCPI handshake and result stream signals.
// slave: the sequencer side. master: host pins plus coprocessor side.
interface pcpi_nibble_sequencer_if #(
  parameter int NIBBLES = 8
);
  logic                 nib_valid;
  logic [3:0]           nib_data;
  logic                 busy;
  logic                 pcpi_valid;
  logic [4*NIBBLES-1:0] pcpi_insn;
  logic                 pcpi_ready;
  logic                 pcpi_wait;
  logic                 pcpi_wr;
  logic [4*NIBBLES-1:0] pcpi_rd;
  logic                 res_valid;
  logic [3:0]           res_nib;
  logic                 res_ack;
  logic                 done;
  logic                 timeout_err;

  modport slave (
    input  nib_valid, nib_data, pcpi_ready, pcpi_wait, pcpi_wr, pcpi_rd, res_ack,
    output busy, pcpi_valid, pcpi_insn, res_valid, res_nib, done, timeout_err
  );

  modport master (
    output nib_valid, nib_data, pcpi_ready, pcpi_wait, pcpi_wr, pcpi_rd, res_ack,
    input  busy, pcpi_valid, pcpi_insn, res_valid, res_nib, done, timeout_err
  );
endinterface

// File: rtl/pcpi_nibble_sequencer.sv
// Nibble-serial host port to 32-bit PCPI sequencer: assembles an instruction, runs the
// valid/ready handshake, streams the result back. Optional watchdog: PCPI_TIMEOUT_EN.
module pcpi_nibble_sequencer #(
  parameter int NIBBLES        = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  pcpi_nibble_sequencer_if.slave      bus,
  output logic [1:0]                  dbg_state
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, OUT} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     insn_q, insn_d;
  logic [W-1:0]     result_q, result_d;
  logic             pcpi_valid_q, pcpi_valid_d;
  logic             done_q, done_d;
  logic             nib_valid_q, nib_valid_d;
  logic             res_ack_q, res_ack_d;
  logic             nib_edge, ack_edge;

`ifdef PCPI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`else
  logic             unused_wait;
  assign unused_wait = bus.pcpi_wait;
`endif

  // Handshake: pcpi_valid holds from the cycle after the last nibble until the cycle after
  // pcpi_ready is sampled; host strobes are edge-detected so a held level counts once.
  assign nib_edge = bus.nib_valid & ~nib_valid_q;
  assign ack_edge = bus.res_ack & ~res_ack_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    insn_d       = insn_q;
    result_d     = result_q;
    pcpi_valid_d = pcpi_valid_q;
    done_d       = 1'b0;
    nib_valid_d  = bus.nib_valid;
    res_ack_d    = bus.res_ack;
`ifdef PCPI_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (nib_edge) begin
          insn_d[3:0] = bus.nib_data;
          idx_d       = IDX_W'(1);
          state_d     = LOAD;
`ifdef PCPI_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (nib_edge) begin
          insn_d[{idx_q, 2'b00} +: 4] = bus.nib_data;
          if (idx_q == LAST) begin
            pcpi_valid_d = 1'b1;
            idx_d        = '0;
            state_d      = ISSUE;
`ifdef PCPI_TIMEOUT_EN
            cnt_d = '0;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        if (bus.pcpi_ready) begin
          pcpi_valid_d = 1'b0;
          if (bus.pcpi_wr) begin
            result_d = bus.pcpi_rd;
            state_d  = OUT;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
`ifdef PCPI_TIMEOUT_EN
        // Ready beats the limit: only reached when ready is low this cycle.
        else if (bus.pcpi_wait) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          pcpi_valid_d  = 1'b0;
          timeout_err_d = 1'b1;
          done_d        = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      OUT: begin
        if (ack_edge) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      insn_q       <= '0;
      result_q     <= '0;
      pcpi_valid_q <= 1'b0;
      done_q       <= 1'b0;
      nib_valid_q  <= 1'b0;
      res_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      insn_q       <= insn_d;
      result_q     <= result_d;
      pcpi_valid_q <= pcpi_valid_d;
      done_q       <= done_d;
      nib_valid_q  <= nib_valid_d;
      res_ack_q    <= res_ack_d;
    end
  end

`ifdef PCPI_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.busy       = (state_q != IDLE);
  assign bus.pcpi_valid = pcpi_valid_q;
  assign bus.pcpi_insn  = insn_q;
  assign bus.res_valid  = (state_q == OUT);
  assign bus.res_nib    = (state_q == OUT) ? result_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign bus.done       = done_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_pcpi_nibble_sequencer.sv
// Directed bench for pcpi_nibble_sequencer: nibble load, PCPI handshake, result stream,
// edge filtering, reset recovery and back-to-back words; watchdog with PCPI_TIMEOUT_EN.
module tb_pcpi_nibble_sequencer;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_fail;
  logic [3:0]  exp_q[$];
  logic [31:0] exp_insn;
  logic [3:0]  nib;
  logic [3:0]  exp_nib;
  logic [31:0] rd_word;

  pcpi_nibble_sequencer_if #(.NIBBLES(8)) bus ();

  pcpi_nibble_sequencer #(.NIBBLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"},        32'(bus.busy),        32'd0);
    chk({tag, " pcpi_valid"},  32'(bus.pcpi_valid),  32'd0);
    chk({tag, " res_valid"},   32'(bus.res_valid),   32'd0);
    chk({tag, " done"},        32'(bus.done),        32'd0);
    chk({tag, " timeout_err"}, 32'(bus.timeout_err), 32'd0);
    chk({tag, " pcpi_insn"},   bus.pcpi_insn,        32'd0);
    chk({tag, " res_nib"},     32'(bus.res_nib),     32'd0);
  endtask

  // driver tasks
  task automatic send_nibble(input logic [3:0] d, input int hold, input bit ack_noise);
    bus.nib_valid = 1'b1;
    bus.nib_data  = d;
    for (int h = 0; h < hold; h++) begin
      if (ack_noise) bus.res_ack = ~bus.res_ack;
      @(negedge clk);
    end
    bus.nib_valid = 1'b0;
    bus.res_ack   = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int hold, input bit ack_noise);
    for (int i = 0; i < 8; i++) begin
      nib = w[4*i +: 4];
      send_nibble(nib, hold, ack_noise);
    end
  endtask

  task automatic respond(input logic wr, input logic [31:0] rd);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = wr;
    bus.pcpi_rd    = rd;
    if (wr) for (int i = 0; i < 8; i++) exp_q.push_back(rd[4*i +: 4]);
    @(negedge clk);
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = $urandom;
  endtask

  // Scoreboard: pops each expected nibble as the DUT presents it, then acks it.
  task automatic drain(input int count, input bit chain_next);
    for (int i = 0; i < count; i++) begin
      exp_nib = exp_q.pop_front();
      chk("res_valid", 32'(bus.res_valid), 32'd1);
      chk("res_nib",   32'(bus.res_nib),   32'(exp_nib));
      bus.res_ack = 1'b1;
      @(negedge clk);
      bus.res_ack = 1'b0;
      if (i == 7) begin
        chk("done pulse", 32'(bus.done), 32'd1);
        chk("busy end",   32'(bus.busy), 32'd0);
        chk("res_valid end", 32'(bus.res_valid), 32'd0);
        if (chain_next) begin
          bus.nib_valid = 1'b1;
          bus.nib_data  = 4'h5;
        end
      end else begin
        chk("done early", 32'(bus.done), 32'd0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.nib_valid  = 1'b0;
    bus.nib_data   = 4'h0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'h0;
    bus.res_ack    = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic transaction with the DEADBEEF result
    send_word(32'h02000033, 1, 1'b0);
    chk("insn basic", bus.pcpi_insn, 32'h02000033);
    chk("pcpi_valid on", 32'(bus.pcpi_valid), 32'd1);
    chk("busy issue", 32'(bus.busy), 32'd1);
    repeat (4) @(negedge clk);
    chk("pcpi_valid held", 32'(bus.pcpi_valid), 32'd1);
    chk("res_valid before ready", 32'(bus.res_valid), 32'd0);
    respond(1'b1, 32'hDEADBEEF);
    chk("pcpi_valid off", 32'(bus.pcpi_valid), 32'd0);
    drain(8, 1'b0);
    chk("done single", 32'(bus.done), 32'd0);
    chk("queue empty", 32'(exp_q.size()), 32'd0);

    // No-write completion
    exp_insn = $urandom;
    send_word(exp_insn, 1, 1'b0);
    chk("insn nowr", bus.pcpi_insn, exp_insn);
    respond(1'b0, 32'hFFFF_FFFF);
    chk("nowr pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("nowr done", 32'(bus.done), 32'd1);
    chk("nowr busy", 32'(bus.busy), 32'd0);
    chk("nowr res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    chk("nowr done off", 32'(bus.done), 32'd0);
    chk("nowr res_valid later", 32'(bus.res_valid), 32'd0);

    // Held strobes count once; res_ack noise during LOAD is ignored; ready outside ISSUE ignored
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    @(negedge clk);
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    chk("ready in idle", 32'(bus.busy), 32'd0);
    exp_insn = {$urandom_range(0, 65535), 16'h0000} | 32'($urandom_range(0, 65535));
    send_word(exp_insn, 5, 1'b1);
    chk("insn held", bus.pcpi_insn, exp_insn);
    chk("held pcpi_valid", 32'(bus.pcpi_valid), 32'd1);
    rd_word = $urandom;
    respond(1'b1, rd_word);
    drain(8, 1'b1);
    // Nibble 0 of the next word was strobed during the done cycle
    bus.nib_valid = 1'b0;
    chk("chain busy", 32'(bus.busy), 32'd1);
    chk("chain nib0", 32'(bus.pcpi_insn[3:0]), 32'h5);
    @(negedge clk);
    for (int i = 1; i < 8; i++) send_nibble(4'(i), 1, 1'b0);
    chk("chain insn", bus.pcpi_insn, 32'h7654_3215);
    respond(1'b0, 32'h0);

    // Reset mid-LOAD
    for (int i = 0; i < 4; i++) send_nibble(4'hF, 1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("rst load");

    // Reset mid-OUT
    send_word(32'hFFFF_FFFF, 1, 1'b0);
    respond(1'b1, 32'hA5A5_A5A5);
    drain(3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk_quiet("rst out");
    send_word(32'h0000_0001, 1, 1'b0);
    chk("clean insn", bus.pcpi_insn, 32'h0000_0001);
    respond(1'b1, 32'h1234_5678);
    drain(8, 1'b0);

`ifdef PCPI_TIMEOUT_EN
    // Watchdog expiry: 16 idle ISSUE cycles after entry
    send_word(32'hCAFE_0001, 1, 1'b0);
    repeat (14) @(negedge clk);
    chk("to before", 32'(bus.pcpi_valid), 32'd1);
    chk("to err before", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    chk("to pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("to err", 32'(bus.timeout_err), 32'd1);
    chk("to done", 32'(bus.done), 32'd1);
    // pcpi_wait toggled every 8 cycles keeps the watchdog from firing
    send_word(32'hCAFE_0002, 1, 1'b0);
    chk("to err cleared", 32'(bus.timeout_err), 32'd0);
    for (int i = 0; i < 48; i++) begin
      if (i % 8 == 0) bus.pcpi_wait = ~bus.pcpi_wait;
      @(negedge clk);
    end
    bus.pcpi_wait = 1'b0;
    chk("wait pcpi_valid", 32'(bus.pcpi_valid), 32'd1);
    chk("wait no err", 32'(bus.timeout_err), 32'd0);
    respond(1'b0, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
